// File: rtl/osram_pkg.sv
// rtl/osram_pkg.sv - shared types and geometry for the output-SRAM requester
package osram_pkg;

    localparam int BANK_ROWS = 6;
    localparam int ROW_DEPTH = 2048;
    localparam int DEPTH     = BANK_ROWS * ROW_DEPTH;
    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 64;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        RD_OUT
    } state_t;

endpackage

// File: rtl/osram_wrap_ptr.sv
// rtl/osram_wrap_ptr.sv - loadable word pointer that increments and wraps at DEPTH
module osram_wrap_ptr #(
    parameter int DEPTH  = osram_pkg::DEPTH,
    parameter int ADDR_W = osram_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] value
);

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            // Wrap explicitly: DEPTH is not a power of two
            value <= (value == ADDR_W'(DEPTH - 1)) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/output_sram_requester.sv
// rtl/output_sram_requester.sv - output-SRAM write/drain requester; optional OSRAM_REQ_TIMEOUT_EN
module output_sram_requester #(
    parameter int DEPTH          = osram_pkg::DEPTH,
    parameter int ADDR_W         = osram_pkg::ADDR_W,
    parameter int DATA_W         = osram_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              wr_base_load,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic              drain_start,
    input  logic [ADDR_W-1:0] drain_base,
    input  logic [ADDR_W-1:0] drain_len,
    output logic              drain_busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              w_en,
    output logic              r_en,
    output logic [31:0]       w_addr,
    output logic [31:0]       r_addr,
    output logic [DATA_W-1:0] w_d,
    input  logic [DATA_W-1:0] r_d,
    input  logic              w_done,
    input  logic              d_ready,
    output logic              err
);
    import osram_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] remaining;
    logic              wr_load;
    logic              wr_inc;
    logic              rd_inc;
    logic              wr_accept;
    logic              drain_ok;
    logic              timed_out;

    // A pointer load owns the cycle: it blocks writes and drains alike
    assign wr_load   = wr_base_load && (int'(wr_base) < DEPTH);
    assign wr_ready  = !reset && (state == IDLE) && !drain_busy && !drain_start && !wr_base_load;
    assign wr_accept = wr_valid && wr_ready;
    assign drain_ok  = (state == IDLE) && !drain_busy && drain_start && !wr_base_load
                     && (int'(drain_base) < DEPTH) && (drain_len != '0);
    assign wr_inc    = (state == WR_WAIT) && (w_done || timed_out);
    assign rd_inc    = (state == RD_OUT) && out_ready;

    // The drain pointer register is the read address; it only moves on a handshake
    assign r_addr    = 32'(rd_ptr);

    osram_wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
        .clock      (clock),
        .reset      (reset),
        .load       (wr_load),
        .load_value (wr_base),
        .inc        (wr_inc),
        .value      (wr_ptr)
    );

    osram_wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
        .clock      (clock),
        .reset      (reset),
        .load       (drain_ok),
        .load_value (drain_base),
        .inc        (rd_inc),
        .value      (rd_ptr)
    );

`ifdef OSRAM_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] wait_cnt;
    logic          waiting;
    logic          done_now;

    assign waiting   = (state == WR_WAIT) || (state == RD_WAIT);
    assign done_now  = ((state == WR_WAIT) && w_done) || ((state == RD_WAIT) && d_ready);
    assign timed_out = waiting && !done_now && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || !waiting) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if (timed_out) begin
            err <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            w_en       <= 1'b0;
            r_en       <= 1'b0;
            w_addr     <= '0;
            w_d        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            drain_busy <= 1'b0;
            remaining  <= '0;
        end else begin
            w_en <= 1'b0;
            r_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (drain_ok) begin
                        state      <= RD_REQ;
                        r_en       <= 1'b1;
                        remaining  <= drain_len;
                        drain_busy <= 1'b1;
                    end else if (wr_accept) begin
                        state  <= WR_REQ;
                        w_en   <= 1'b1;
                        w_addr <= 32'(wr_ptr);
                        w_d    <= wr_data;
                    end
                end
                WR_REQ:  state <= WR_WAIT;
                WR_WAIT: begin
                    if (w_done || timed_out) state <= IDLE;
                end
                RD_REQ:  state <= RD_WAIT;
                RD_WAIT: begin
                    if (d_ready) begin
                        out_data  <= r_d;
                        out_valid <= 1'b1;
                        state     <= RD_OUT;
                    end else if (timed_out) begin
                        state      <= IDLE;
                        drain_busy <= 1'b0;
                    end
                end
                RD_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (remaining == ADDR_W'(1)) begin
                            state      <= IDLE;
                            drain_busy <= 1'b0;
                        end else begin
                            state <= RD_REQ;
                            r_en  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_sram_requester.sv
// tb/tb_output_sram_requester.sv - directed self-checking bench for output_sram_requester
module tb_output_sram_requester;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [63:0] wr_data = '0;
    logic        wr_ready;
    logic        wr_base_load = 1'b0;
    logic [13:0] wr_base = '0;
    logic        drain_start = 1'b0;
    logic [13:0] drain_base = '0;
    logic [13:0] drain_len = '0;
    logic        drain_busy;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready = 1'b0;
    logic        w_en;
    logic        r_en;
    logic [31:0] w_addr;
    logic [31:0] r_addr;
    logic [63:0] w_d;
    logic [63:0] r_d = '0;
    logic        w_done = 1'b0;
    logic        d_ready = 1'b0;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    output_sram_requester dut (
        .clock        (clock),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .wr_base_load (wr_base_load),
        .wr_base      (wr_base),
        .drain_start  (drain_start),
        .drain_base   (drain_base),
        .drain_len    (drain_len),
        .drain_busy   (drain_busy),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .w_en         (w_en),
        .r_en         (r_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .w_d          (w_d),
        .r_d          (r_d),
        .w_done       (w_done),
        .d_ready      (d_ready),
        .err          (err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_base(input int base);
        wr_base_load = 1'b1;
        wr_base = 14'(base);
        #1;
        chk1("wr_ready_during_load", wr_ready, 1'b0);
        step();
        wr_base_load = 1'b0;
    endtask

    // Accept in N, w_en in N+1, w_done driven in N+3, wr_ready back in N+4
    task automatic do_write(input logic [63:0] data, input int addr);
        wr_valid = 1'b1;
        wr_data = data;
        #1;
        chk1("wr_ready_idle", wr_ready, 1'b1);
        step();
        wr_valid = 1'b0;
        wr_data = '0;
        chk1("w_en_pulse", w_en, 1'b1);
        chkv("w_addr", 64'(w_addr), 64'(addr));
        chkv("w_d", w_d, data);
        chk1("r_en_excl", r_en, 1'b0);
        chk1("wr_ready_after_accept", wr_ready, 1'b0);
        step();
        chk1("w_en_single", w_en, 1'b0);
        chkv("w_addr_hold", 64'(w_addr), 64'(addr));
        step();
        chkv("w_d_hold", w_d, data);
        w_done = 1'b1;
        #1;
        chk1("wr_ready_in_wait", wr_ready, 1'b0);
        step();
        w_done = 1'b0;
        #1;
        chk1("wr_ready_back", wr_ready, 1'b1);
    endtask

    initial begin
        step();
        step();
        chk1("rst_wr_ready", wr_ready, 1'b0);
        chk1("rst_w_en", w_en, 1'b0);
        chk1("rst_r_en", r_en, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_drain_busy", drain_busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chkv("rst_w_addr", 64'(w_addr), 64'd0);
        chkv("rst_r_addr", 64'(r_addr), 64'd0);
        chkv("rst_w_d", w_d, 64'd0);
        chkv("rst_out_data", out_data, 64'd0);
        reset = 1'b0;
        #1;
        chk1("wr_ready_post_reset", wr_ready, 1'b1);

        load_base(0);
        do_write(64'hA0, 0);
        do_write(64'hA1, 1);
        do_write(64'hA2, 2);

        load_base(12287);
        do_write(64'hB0, 12287);
        do_write(64'hB1, 0);

        load_base(12300);
        do_write(64'hC0, 1);

        // Drain 2047..2048 with a stalled consumer on the first word
        drain_start = 1'b1;
        drain_base = 14'd2047;
        drain_len = 14'd2;
        #1;
        chk1("wr_ready_drain_start", wr_ready, 1'b0);
        step();
        drain_start = 1'b0;
        chk1("drain_busy_set", drain_busy, 1'b1);
        chk1("r_en_first", r_en, 1'b1);
        chk1("w_en_excl", w_en, 1'b0);
        chkv("r_addr_first", 64'(r_addr), 64'd2047);
        step();
        chk1("r_en_single", r_en, 1'b0);
        chkv("r_addr_hold", 64'(r_addr), 64'd2047);
        step();
        d_ready = 1'b1;
        r_d = 64'h11;
        step();
        d_ready = 1'b0;
        r_d = 64'hDEAD;
        for (int i = 0; i < 5; i++) begin
            chk1("out_valid_stall", out_valid, 1'b1);
            chkv("out_data_stall", out_data, 64'h11);
            chk1("r_en_stall", r_en, 1'b0);
            step();
        end
        out_ready = 1'b1;
        chkv("out_data_before_hs", out_data, 64'h11);
        step();
        chk1("r_en_second", r_en, 1'b1);
        chkv("r_addr_second", 64'(r_addr), 64'd2048);
        chk1("out_valid_cleared", out_valid, 1'b0);
        chk1("drain_busy_mid", drain_busy, 1'b1);
        step();
        step();
        d_ready = 1'b1;
        r_d = 64'h22;
        step();
        d_ready = 1'b0;
        chk1("out_valid_second", out_valid, 1'b1);
        chkv("out_data_second", out_data, 64'h22);
        chk1("drain_busy_last", drain_busy, 1'b1);
        step();
        out_ready = 1'b0;
        #1;
        chk1("drain_busy_done", drain_busy, 1'b0);
        chk1("out_valid_done", out_valid, 1'b0);
        chk1("wr_ready_after_drain", wr_ready, 1'b1);

        // Drain and write offered together: the drain wins
        drain_start = 1'b1;
        drain_base = 14'd5;
        drain_len = 14'd1;
        wr_valid = 1'b1;
        wr_data = 64'hBB;
        #1;
        chk1("wr_ready_collide", wr_ready, 1'b0);
        step();
        drain_start = 1'b0;
        chk1("collide_r_en", r_en, 1'b1);
        chk1("collide_w_en", w_en, 1'b0);
        chkv("collide_r_addr", 64'(r_addr), 64'd5);
        #1;
        chk1("collide_wr_ready_busy", wr_ready, 1'b0);
        step();
        step();
        d_ready = 1'b1;
        r_d = 64'h33;
        step();
        d_ready = 1'b0;
        #1;
        chkv("collide_out_data", out_data, 64'h33);
        chk1("collide_wr_ready_out", wr_ready, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk1("collide_drain_done", drain_busy, 1'b0);
        do_write(64'hBB, 2);

        // Zero-length and out-of-range drains are ignored
        drain_start = 1'b1;
        drain_base = 14'd7;
        drain_len = 14'd0;
        step();
        drain_start = 1'b0;
        chk1("len0_busy", drain_busy, 1'b0);
        chk1("len0_r_en", r_en, 1'b0);
        step();
        chk1("len0_r_en_later", r_en, 1'b0);
        drain_start = 1'b1;
        drain_base = 14'd12288;
        drain_len = 14'd3;
        step();
        drain_start = 1'b0;
        chk1("badbase_busy", drain_busy, 1'b0);
        chk1("badbase_r_en", r_en, 1'b0);

        // Stray completions in IDLE change nothing
        w_done = 1'b1;
        d_ready = 1'b1;
        step();
        w_done = 1'b0;
        d_ready = 1'b0;
        chk1("stray_out_valid", out_valid, 1'b0);
        do_write(64'hD0, 3);

        // Withheld w_done
        wr_valid = 1'b1;
        wr_data = 64'hE0;
        #1;
        step();
        wr_valid = 1'b0;
        chk1("to_w_en", w_en, 1'b1);
        chkv("to_w_addr", 64'(w_addr), 64'd4);
        repeat (16) step();
        chk1("to_err_not_yet", err, 1'b0);
        chk1("to_wr_ready_not_yet", wr_ready, 1'b0);
        step();
`ifdef OSRAM_REQ_TIMEOUT_EN
        chk1("to_err_set", err, 1'b1);
        chk1("to_idle", wr_ready, 1'b1);
        do_write(64'hE1, 5);
        chk1("to_err_sticky", err, 1'b1);
`else
        chk1("stuck_err", err, 1'b0);
        chk1("stuck_wr_ready", wr_ready, 1'b0);
        chkv("stuck_w_addr", 64'(w_addr), 64'd4);
        repeat (20) step();
        chk1("stuck_err_later", err, 1'b0);
        chk1("stuck_wr_ready_later", wr_ready, 1'b0);
`endif

        // Reset aborts whatever is in flight
        reset = 1'b1;
        step();
        chk1("abort_w_en", w_en, 1'b0);
        chk1("abort_err", err, 1'b0);
        chkv("abort_w_addr", 64'(w_addr), 64'd0);
        reset = 1'b0;
        drain_start = 1'b1;
        drain_base = 14'd9;
        drain_len = 14'd1;
        step();
        drain_start = 1'b0;
        chk1("abort_r_en_pre", r_en, 1'b1);
        reset = 1'b1;
        step();
        chk1("abort_r_en", r_en, 1'b0);
        chk1("abort_drain_busy", drain_busy, 1'b0);
        chkv("abort_r_addr", 64'(r_addr), 64'd0);
        reset = 1'b0;
        do_write(64'hF0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
